// File: rtl/cv32e40p_instr_decrypt.sv
// Instruction decryption between prefetch buffer and aligner: tracks fetch addresses,
// derives a per-address keystream and mirrors the prefetch FIFO with stored keystreams.
module cv32e40p_instr_decrypt #(
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned FIFO_ADDR_DEPTH = 1,
  parameter int unsigned OUTSTND_DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable_i,
  input  logic                       key_we_i,
  input  logic [63:0]                key_i,
  input  logic                       instr_req_i,
  input  logic                       instr_gnt_i,
  input  logic [31:0]                instr_addr_i,
  input  logic                       instr_rvalid_i,
  input  logic                       fifo_push_i,
  input  logic                       fifo_pop_i,
  input  logic [FIFO_ADDR_DEPTH-1:0] fifo_write_pointer_i,
  input  logic [FIFO_ADDR_DEPTH-1:0] fifo_read_pointer_i,
  input  logic                       branch_i,
  input  logic [31:0]                cipher_i,
  output logic [31:0]                plain_o,
  output logic                       err_o
);

  localparam int unsigned QW  = (OUTSTND_DEPTH > 1) ? $clog2(OUTSTND_DEPTH) : 1;
  localparam int unsigned QCW = $clog2(OUTSTND_DEPTH + 1);
  localparam int unsigned SCW = $clog2(FIFO_DEPTH + 1);

  function automatic logic [31:0] keystream(input logic [31:0] addr, input logic [63:0] key);
    logic [31:0] w;
    logic [31:0] t;
    w = addr & 32'hFFFF_FFFC;
    t = w ^ key[63:32];
    return key[31:0] ^ {t[26:0], t[31:27]} ^ {w[15:0], w[31:16]};
  endfunction

  function automatic logic [QW-1:0] next_qptr(input logic [QW-1:0] p);
    return (p == QW'(OUTSTND_DEPTH - 1)) ? '0 : p + QW'(1);
  endfunction

  logic [63:0]     key_q;
  logic [31:0]     q_addr_q [OUTSTND_DEPTH];
  logic [QW-1:0]   q_head_q, q_tail_q;
  logic [QCW-1:0]  q_cnt_q, q_cnt_d;
  logic [31:0]     ks_mem_q [FIFO_DEPTH];
  logic [SCW-1:0]  s_cnt_q, s_cnt_d;
  logic            err_q, err_d;

  logic            q_grant, q_empty, q_full, q_bypass, q_push, q_pop;
  logic            s_empty, s_full;
  logic [31:0]     ks_resp;

  assign q_grant  = instr_req_i & instr_gnt_i;
  assign q_empty  = (q_cnt_q == '0);
  assign q_full   = (q_cnt_q == QCW'(OUTSTND_DEPTH));
  // Grant and response with an empty queue: the granted address is consumed on the spot.
  assign q_bypass = q_empty & q_grant & instr_rvalid_i;
  assign q_push   = q_grant & ~q_bypass & (~q_full | instr_rvalid_i);
  assign q_pop    = instr_rvalid_i & ~q_empty;
  assign ks_resp  = keystream(q_empty ? instr_addr_i : q_addr_q[q_head_q], key_q);

  assign s_empty  = (s_cnt_q == '0);
  assign s_full   = (s_cnt_q == SCW'(FIFO_DEPTH));

  always_comb begin
    q_cnt_d = q_cnt_q;
    if (q_push && !q_pop)      q_cnt_d = q_cnt_q + QCW'(1);
    else if (q_pop && !q_push) q_cnt_d = q_cnt_q - QCW'(1);

    s_cnt_d = s_cnt_q;
    if (branch_i)                                   s_cnt_d = '0;
    else if (fifo_push_i && !fifo_pop_i && !s_full) s_cnt_d = s_cnt_q + SCW'(1);
    else if (fifo_pop_i && !fifo_push_i && !s_empty) s_cnt_d = s_cnt_q - SCW'(1);

    err_d = err_q
          | (q_grant & q_full & ~instr_rvalid_i)
          | (instr_rvalid_i & q_empty & ~q_grant)
          | (fifo_push_i & s_full)
          | (fifo_pop_i & s_empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q    <= '0;
      q_head_q <= '0;
      q_tail_q <= '0;
      q_cnt_q  <= '0;
      s_cnt_q  <= '0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < OUTSTND_DEPTH; i++) q_addr_q[i] <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++)    ks_mem_q[i] <= '0;
    end else begin
      if (key_we_i) key_q <= key_i;
      if (q_push) begin
        q_addr_q[q_tail_q] <= instr_addr_i;
        q_tail_q           <= next_qptr(q_tail_q);
      end
      if (q_pop) q_head_q <= next_qptr(q_head_q);
      if (fifo_push_i) ks_mem_q[fifo_write_pointer_i] <= ks_resp;
      q_cnt_q <= q_cnt_d;
      s_cnt_q <= s_cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    plain_o = cipher_i;
    if (enable_i) begin
      if (s_empty) plain_o = cipher_i ^ ks_resp;
      else         plain_o = cipher_i ^ ks_mem_q[fifo_read_pointer_i];
    end
  end

  assign err_o = err_q;

endmodule
